// File: rtl/fb_write_scheduler.sv
// Write-port scheduler for the 320x240 RGB12 frame buffer: round-robin arbitration of two
// draw-point requesters plus a full-frame clear sequencer. Optional: FB_WRITE_SCHEDULER_DROP_CNT_EN.
module fb_write_scheduler #(
   parameter int unsigned BUF_H_RES = 320,
   parameter int unsigned BUF_V_RES = 240
) (
   input  logic        piul1Clock,
   input  logic        piul1Reset,
   input  logic        piul1Req0,
   input  logic        piul1Req1,
   input  logic [8:0]  piul9PosX0,
   input  logic [8:0]  piul9PosX1,
   input  logic [8:0]  piul9PosY0,
   input  logic [8:0]  piul9PosY1,
   input  logic [11:0] piul12Rgb0,
   input  logic [11:0] piul12Rgb1,
   output logic        poul1Gnt0,
   output logic        poul1Gnt1,
   input  logic        piul1ClearStart,
   input  logic [11:0] piul12ClearRgb,
   output logic        poul1ClearBusy,
   output logic        poul1Update,
   output logic [8:0]  poul9PosX,
   output logic [8:0]  poul9PosY,
   output logic [11:0] poul12Rgb
`ifdef FB_WRITE_SCHEDULER_DROP_CNT_EN
   ,
   output logic [15:0] poul16DropCount
`endif
);

   localparam logic [8:0] XLast = 9'(BUF_H_RES - 1);
   localparam logic [8:0] YLast = 9'(BUF_V_RES - 1);

   typedef enum logic [0:0] {StArb, StClear} state_e;

   state_e      state_q, state_d;
   logic        rr_q, rr_d;
   logic [8:0]  cnt_x_q, cnt_x_d;
   logic [8:0]  cnt_y_q, cnt_y_d;
   logic [11:0] clear_rgb_q, clear_rgb_d;
   logic        update_q, update_d;
   logic [8:0]  pos_x_q, pos_x_d;
   logic [8:0]  pos_y_q, pos_y_d;
   logic [11:0] rgb_q, rgb_d;

   logic        gnt0, gnt1;
   logic [8:0]  sel_x, sel_y;
   logic [11:0] sel_rgb;
   logic        sel_ok;

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      cnt_x_d     = cnt_x_q;
      cnt_y_d     = cnt_y_q;
      clear_rgb_d = clear_rgb_q;
      update_d    = 1'b0;
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      rgb_d       = rgb_q;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      sel_x       = piul9PosX0;
      sel_y       = piul9PosY0;
      sel_rgb     = piul12Rgb0;
      sel_ok      = 1'b0;

      unique case (state_q)
         StArb: begin
            if (piul1ClearStart) begin
               // The first sweep write (0,0) is registered here so it lands with ClearBusy.
               clear_rgb_d = piul12ClearRgb;
               cnt_x_d     = '0;
               cnt_y_d     = '0;
               update_d    = 1'b1;
               pos_x_d     = '0;
               pos_y_d     = '0;
               rgb_d       = piul12ClearRgb;
               state_d     = StClear;
            end else if (!piul1Reset) begin
               gnt0 = piul1Req0 & (~piul1Req1 | ~rr_q);
               gnt1 = piul1Req1 & ~gnt0;
               if (gnt1) begin
                  sel_x   = piul9PosX1;
                  sel_y   = piul9PosY1;
                  sel_rgb = piul12Rgb1;
               end
               sel_ok = (sel_x <= XLast) && (sel_y <= YLast);
               if (gnt0 || gnt1) begin
                  rr_d = gnt0;
                  if (sel_ok) begin
                     update_d = 1'b1;
                     pos_x_d  = sel_x;
                     pos_y_d  = sel_y;
                     rgb_d    = sel_rgb;
                  end
               end
            end
         end
         StClear: begin
            if ((cnt_x_q == XLast) && (cnt_y_q == YLast)) begin
               state_d = StArb;
            end else begin
               if (cnt_x_q == XLast) begin
                  cnt_x_d = '0;
                  cnt_y_d = cnt_y_q + 9'd1;
               end else begin
                  cnt_x_d = cnt_x_q + 9'd1;
               end
               update_d = 1'b1;
               pos_x_d  = cnt_x_d;
               pos_y_d  = cnt_y_d;
               rgb_d    = clear_rgb_q;
            end
         end
         default: state_d = StArb;
      endcase
   end

   always_ff @(posedge piul1Clock) begin
      if (piul1Reset) begin
         state_q     <= StArb;
         rr_q        <= 1'b0;
         cnt_x_q     <= '0;
         cnt_y_q     <= '0;
         clear_rgb_q <= '0;
         update_q    <= 1'b0;
         pos_x_q     <= '0;
         pos_y_q     <= '0;
         rgb_q       <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         cnt_x_q     <= cnt_x_d;
         cnt_y_q     <= cnt_y_d;
         clear_rgb_q <= clear_rgb_d;
         update_q    <= update_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         rgb_q       <= rgb_d;
      end
   end

`ifdef FB_WRITE_SCHEDULER_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if ((gnt0 || gnt1) && !sel_ok && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge piul1Clock) begin
      if (piul1Reset) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign poul16DropCount = drop_cnt_q;
`endif

   assign poul1Gnt0      = gnt0;
   assign poul1Gnt1      = gnt1;
   assign poul1ClearBusy = (state_q == StClear);
   assign poul1Update    = update_q;
   assign poul9PosX      = pos_x_q;
   assign poul9PosY      = pos_y_q;
   assign poul12Rgb      = rgb_q;

endmodule
